// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Holds the requester tag and the RAM geometry constants.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 6;
    localparam int RAM_DATA_W = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way grant logic with a last-winner pointer (round-robin).
// Build with RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN

    wire unused_ok = &{1'b0, clk};

    // A always wins; B only gets the port when A is idle
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            a_gnt = a_req;
            b_gnt = b_req && !a_req;
        end
    end

`else

    logic last_b;

    // Remember who moved last; a grant is always a transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (a_gnt || b_gnt) begin
            last_b <= b_gnt;
        end
    end

    // Alternate on contention, otherwise serve whoever asks
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                a_gnt = last_b;
                b_gnt = !last_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-read single-port RAM between requesters A and B.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    logic    a_gnt;
    logic    b_gnt;
    logic    rd_pend;
    req_id_t rd_tag;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .a_req (a_valid),
        .b_req (b_valid),
        .a_gnt (a_gnt),
        .b_gnt (b_gnt)
    );

    assign a_ready = a_gnt;
    assign b_ready = b_gnt;

    // Steer the winner onto the RAM port; idle port is all zero
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        if (a_gnt) begin
            ram_we   = a_we;
            ram_addr = a_addr;
            ram_data = a_wdata;
        end else if (b_gnt) begin
            ram_we   = b_we;
            ram_addr = b_addr;
            ram_data = b_wdata;
        end
    end

    // Tag an accepted read so its data returns to the issuer next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_tag  <= REQ_A;
        end else begin
            rd_pend <= (a_gnt || b_gnt) && !ram_we;
            rd_tag  <= b_gnt ? REQ_B : REQ_A;
        end
    end

    // Route the registered RAM output to the tagged requester only
    always_comb begin
        a_rvalid = 1'b0;
        b_rvalid = 1'b0;
        a_rdata  = '0;
        b_rdata  = '0;
        if (rd_pend) begin
            if (rd_tag == REQ_B) begin
                b_rvalid = 1'b1;
                b_rdata  = ram_q;
            end else begin
                a_rvalid = 1'b1;
                a_rdata  = ram_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 64x8 RAM model.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, a_ready, a_we = 1'b0, a_rvalid;
    logic [5:0] a_addr = '0;
    logic [7:0] a_wdata = '0, a_rdata;
    logic       b_valid = 1'b0, b_ready, b_we = 1'b0, b_rvalid;
    logic [5:0] b_addr = '0;
    logic [7:0] b_wdata = '0, b_rdata;
    logic [7:0] ram_data, ram_q;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] mem [64];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we),
        .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we),
        .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_q(ram_q)
    );

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        ram_q = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_cmd(input logic v, input logic we,
                         input logic [5:0] ad, input logic [7:0] wd);
        a_valid = v; a_we = we; a_addr = ad; a_wdata = wd;
    endtask

    task automatic b_cmd(input logic v, input logic we,
                         input logic [5:0] ad, input logic [7:0] wd);
        b_valid = v; b_we = we; b_addr = ad; b_wdata = wd;
    endtask

    initial begin
        // mixed collision, both valid while in reset
        tick();
        a_cmd(1, 1, 6'd4, 8'h09);
        b_cmd(1, 0, 6'd4, 8'h00);
        #1;
        check("rst_a_ready", a_ready, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_b_rvalid", b_rvalid, 0);
        check("rst_b_rdata", b_rdata, 0);
        tick();
        rst = 1'b0;
        #1;
        check("mix_a_ready", a_ready, 1);
        check("mix_b_stall", b_ready, 0);
        check("mix_ram_we", ram_we, 1);
        check("mix_ram_addr", ram_addr, 4);
        check("mix_ram_data", ram_data, 8'h09);
        tick();
        a_cmd(0, 0, 6'd0, 8'h00);
        #1;
        check("mix_b_ready", b_ready, 1);
        check("mix_b_rd_we", ram_we, 0);
        check("mix_b_rd_addr", ram_addr, 4);
        tick();
        b_cmd(0, 0, 6'd0, 8'h00);
        #1;
        check("mix_b_rvalid", b_rvalid, 1);
        check("mix_b_rdata", b_rdata, 8'h09);
        check("mix_a_rvalid", a_rvalid, 0);

        // single requester: four writes then three pipelined reads
        tick(); a_cmd(1, 1, 6'd0, 8'h01); #1;
        check("wr0_ready", a_ready, 1);
        check("wr0_we", ram_we, 1);
        tick(); a_cmd(1, 1, 6'd1, 8'h06); #1;
        check("wr1_ready", a_ready, 1);
        tick(); a_cmd(1, 1, 6'd2, 8'h02); #1;
        check("wr2_ready", a_ready, 1);
        tick(); a_cmd(1, 1, 6'd3, 8'h04); #1;
        check("wr3_ready", a_ready, 1);
        check("wr3_data", ram_data, 8'h04);
        tick(); a_cmd(1, 0, 6'd0, 8'h00); #1;
        check("rd0_ready", a_ready, 1);
        check("rd0_we", ram_we, 0);
        check("wr_no_resp", a_rvalid, 0);
        tick(); a_cmd(1, 0, 6'd1, 8'h00); #1;
        check("rd1_ready", a_ready, 1);
        check("rd0_rvalid", a_rvalid, 1);
        check("rd0_rdata", a_rdata, 8'h01);
        tick(); a_cmd(1, 0, 6'd2, 8'h00); #1;
        check("rd2_ready", a_ready, 1);
        check("rd1_rdata", a_rdata, 8'h06);
        tick(); a_cmd(0, 0, 6'd0, 8'h00); #1;
        check("rd2_rvalid", a_rvalid, 1);
        check("rd2_rdata", a_rdata, 8'h02);
        check("rd_b_quiet", b_rvalid, 0);
        tick(); #1;
        check("rd_done", a_rvalid, 0);

        // read after write to the same address on the next cycle
        tick(); a_cmd(1, 1, 6'd5, 8'h0A); #1;
        check("raw_wr", ram_we, 1);
        tick(); a_cmd(1, 0, 6'd5, 8'h00); #1;
        check("raw_rd", a_ready, 1);
        tick(); a_cmd(0, 0, 6'd0, 8'h00); #1;
        check("raw_rdata", a_rdata, 8'h0A);

        // reset while a read response is due
        tick(); a_cmd(1, 0, 6'd1, 8'h00); #1;
        check("rr_accept", a_ready, 1);
        tick(); a_cmd(1, 0, 6'd1, 8'h00); #1;
        check("rr_rvalid_pre", a_rvalid, 1);
        rst = 1'b1;
        #1;
        check("rr_rvalid_drop", a_rvalid, 0);
        check("rr_ram_we", ram_we, 0);
        check("rr_ram_addr", ram_addr, 0);
        check("rr_a_ready", a_ready, 0);
        tick(); a_cmd(0, 0, 6'd0, 8'h00); rst = 1'b0; #1;
        check("rr_no_stale", a_rvalid, 0);
        tick(); #1;
        check("rr_no_stale2", a_rvalid, 0);

`ifdef RAM_ARB_FIXED_PRIO_EN
        // both valid for four cycles: A always wins
        tick();
        a_cmd(1, 0, 6'd0, 8'h00);
        b_cmd(1, 0, 6'd3, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("fix_a_ready", a_ready, 1);
            check("fix_b_ready", b_ready, 0);
            check("fix_ram_addr", ram_addr, 0);
            tick();
        end
        a_cmd(0, 0, 6'd0, 8'h00);
        b_cmd(0, 0, 6'd0, 8'h00);
        #1;
        check("fix_b_none", b_rvalid, 0);
        tick(); #1;
        check("fix_idle", a_rvalid, 0);
`else
        // contention after reset: A first, then strict alternation
        tick();
        a_cmd(1, 0, 6'd0, 8'h00);
        b_cmd(1, 0, 6'd3, 8'h00);
        #1;
        check("ct0_a_ready", a_ready, 1);
        check("ct0_b_ready", b_ready, 0);
        check("ct0_addr", ram_addr, 0);
        tick(); #1;
        check("ct1_b_ready", b_ready, 1);
        check("ct1_a_ready", a_ready, 0);
        check("ct1_addr", ram_addr, 3);
        check("ct1_a_rvalid", a_rvalid, 1);
        check("ct1_a_rdata", a_rdata, 8'h01);
        check("ct1_b_rvalid", b_rvalid, 0);
        tick(); #1;
        check("ct2_a_ready", a_ready, 1);
        check("ct2_b_rvalid", b_rvalid, 1);
        check("ct2_b_rdata", b_rdata, 8'h04);
        check("ct2_a_rvalid", a_rvalid, 0);
        check("ct2_a_rdata", a_rdata, 0);
        tick(); #1;
        check("ct3_b_ready", b_ready, 1);
        check("ct3_a_rdata", a_rdata, 8'h01);
        tick();
        a_cmd(0, 0, 6'd0, 8'h00);
        b_cmd(0, 0, 6'd0, 8'h00);
        #1;
        check("ct4_b_rdata", b_rdata, 8'h04);
        check("ct4_a_rvalid", a_rvalid, 0);
`endif

        // hold/retract: B stalled by A for one cycle, then gives up
        tick();
        a_cmd(1, 0, 6'd2, 8'h00);
        b_cmd(1, 1, 6'd7, 8'h55);
        #1;
        check("hr_a_ready", a_ready, 1);
        check("hr_b_stall", b_ready, 0);
        check("hr_ram_we", ram_we, 0);
        tick();
        a_cmd(0, 0, 6'd0, 8'h00);
        b_cmd(0, 0, 6'd0, 8'h00);
        #1;
        check("hr_b_ready", b_ready, 0);
        check("hr_idle_we", ram_we, 0);
        check("hr_idle_addr", ram_addr, 0);
        check("hr_a_rdata", a_rdata, 8'h02);
        check("hr_b_rvalid", b_rvalid, 0);
        tick(); #1;
        check("hr_b_rvalid2", b_rvalid, 0);
        tick(); a_cmd(1, 0, 6'd7, 8'h00); #1;
        check("hr_probe_rd", a_ready, 1);
        tick(); a_cmd(0, 0, 6'd0, 8'h00); #1;
        check("hr_no_write", a_rdata, 8'h00);
        check("hr_probe_rv", a_rvalid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
